exit_watchdog: RTL and testbench
================================

# exit_watchdog

Synthesizable, parametrised successor of the testbench exit/abort logic. Holds off a configurable number of cycles after reset, emits a one-cycle start pulse, then monitors `NUM_CH` independent exit channels plus a programmable cycle limit and latches a sticky pass/fail/timeout verdict. It sits between the SoC exit registers (one channel per core or harness) and the bench or FPGA status logic, replacing the per-bench `always` blocks.

## Interface
- `NUM_CH`, default 2: number of exit channels, 1..16.
- `VALUE_W`, default 32: exit value width.
- `CNT_W`, default 32: cycle counter width.
- `RESET_WAIT`, default 50: cycles held in WAIT after reset release. Must be at least 1.
- `MODE_ALL`, default 0: 0 finishes on the first exit; 1 finishes when every channel has exited.
- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `max_cycles_i` in `CNT_W`: RUN-phase cycle limit; 0 disables the timeout. Sampled every cycle.
- `exit_valid_i` in `NUM_CH`: per-channel exit strobe.
- `exit_value_i` in `NUM_CH*VALUE_W`: per-channel exit value. Channel k occupies `[k*VALUE_W +: VALUE_W]`.
- `start_o` out 1: one-cycle pulse marking the end of the reset hold-off (firmware-load trigger).
- `busy_o` out 1: high in RUN.
- `done_o` out 1: sticky verdict valid.
- `pass_o` out 1: sticky; valid with `done_o`. Set when all recorded exits are 0 and no timeout occurred.
- `timeout_o` out 1: sticky; cycle limit reached.
- `exited_o` out `NUM_CH`: channels seen exiting.
- `fail_ch_o` out `$clog2(NUM_CH)` (min 1): first failing channel.
- `fail_value_o` out `VALUE_W`: value of the first failing exit.
- `cycle_cnt_o` out `CNT_W`: RUN cycles elapsed.

## Operation
- FSM states are WAIT, START, RUN and DONE. Reset enters WAIT.
- **WAIT:** a hold-off counter counts `RESET_WAIT` cycles, then moves to START. Exits arriving in WAIT are ignored.
- **START:** lasts one cycle; `start_o`=1. Always moves to RUN.
- **RUN:**
  - `cycle_cnt` increments each cycle and saturates at all-ones.
  - On each `exit_valid_i[k]`, set `exited[k]`. The first value per channel is kept; repeat strobes on that channel are ignored.
  - Fail capture:
    - A nonzero value with no fail yet recorded captures `fail_ch` and `fail_value`.
    - Simultaneous nonzero exits: the lowest index wins.
    - Later failures never overwrite the capture.
  - Finish condition:
    - `MODE_ALL`=0: finish when any valid exit is seen.
    - `MODE_ALL`=1: finish when `exited | exit_valid_i` is all ones.
  - Timeout: `max_cycles_i`≠0 and `cycle_cnt` ≥ `max_cycles_i` while the finish condition is false. Sets `timeout`.
  - Either finish or timeout moves to DONE.
  - Finish and timeout in the same cycle: finish wins and `timeout_o` stays 0.
- **DONE:** absorbing; all inputs ignored. `pass_o` = no fail recorded AND no timeout. Only `rst_i` leaves DONE.
- `rst_i` mid-RUN or in DONE clears all state and restarts WAIT with the full hold-off.

## Timing
- All outputs are registered.
- Reset values: `start_o`, `busy_o`, `done_o`, `pass_o`, `timeout_o` are 0; `exited_o`, `fail_ch_o`, `fail_value_o`, `cycle_cnt_o` are 0.
- Let reset deassert at edge 0:
  - `start_o` is high in cycle `RESET_WAIT`.
  - `busy_o` rises in cycle `RESET_WAIT`+1.
  - `cycle_cnt_o` reads 0 in the first RUN cycle.
- An exit sampled at edge n gives `done_o`/`pass_o` high from cycle n+1, with `busy_o` low in the same cycle.
- A timeout with `max_cycles_i`=M gives `done_o` in RUN cycle M+1, counting the first RUN cycle as cycle 0.
- No handshake: exit strobes are level-sampled once per cycle. A strobe held over several cycles equals one exit.

## Structure
- Package `exit_watchdog_pkg`:
  - FSM state enum `ew_state_e` (WAIT, START, RUN, DONE).
  - Function `first_set_idx` returning the lowest set bit and a found flag, used for fail-channel priority.
- Sub-module `ew_sat_counter`: `CNT_W`-wide synchronous-clear, enable, saturating counter. Instantiated twice, for the hold-off counter and the RUN cycle counter.
- FSM and capture logic live in the top module.

## Test plan
- **Reset hold-off:** `RESET_WAIT`=50, release reset. `start_o` pulses exactly once, in cycle 50; `busy_o` rises in cycle 51.
- **Single pass:** `MODE_ALL`=0, ch1 exits with 0 at RUN cycle 10. `done_o`=1, `pass_o`=1, `exited_o`=2'b10, `cycle_cnt_o`=11.
- **Simultaneous fail:**
  - Ch0 exits 7 and ch1 exits 3 in the same cycle.
  - `fail_ch_o`=0, `fail_value_o`=7, `pass_o`=0.
  - A later ch1 exit of 9 is ignored.
- **All-mode:** `MODE_ALL`=1.
  - Ch0 exits 0 at cycle 5: not done.
  - Ch1 exits 0 at cycle 20: `done_o` next cycle, `pass_o`=1.
  - Also, if ch1 instead exits 4: `pass_o`=0, `fail_ch_o`=1.
- **Timeout and tie:**
  - `max_cycles_i`=100, no exit: `timeout_o`=1, `pass_o`=0 at RUN cycle 101.
  - Repeat with an exit of 0 on the exact timeout cycle: `timeout_o`=0, `pass_o`=1.
  - `max_cycles_i`=0 never times out over 10k cycles.
- **Reset mid-run:** assert `rst_i` in RUN and in DONE. All outputs return to 0, and the full 50-cycle hold-off repeats. Exits during WAIT leave `exited_o`=0.

Source files
------------

// File: rtl/exit_watchdog_pkg.sv
// Shared types and helpers for the exit watchdog.
// FSM state encoding and the fail-channel priority search.
package exit_watchdog_pkg;

    localparam int EW_MAX_CH = 16;

    typedef enum logic [1:0] {
        S_WAIT,
        S_START,
        S_RUN,
        S_DONE
    } ew_state_e;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } ew_first_t;

    // Lowest set bit wins, so channel 0 has the highest priority.
    function automatic ew_first_t first_set_idx(
        input logic [EW_MAX_CH-1:0] vec
    );
        ew_first_t r;
        r.found = 1'b0;
        r.idx   = 4'd0;
        for (int i = EW_MAX_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ew_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// Holds at all-ones instead of wrapping.
module ew_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Clear has priority; count only while enabled and below all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/exit_watchdog.sv
// Reset hold-off, start pulse and multi-channel exit monitor.
// Latches a sticky pass/fail/timeout verdict until reset.
module exit_watchdog
    import exit_watchdog_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int VALUE_W    = 32,
    parameter int CNT_W      = 32,
    parameter int RESET_WAIT = 50,
    parameter int MODE_ALL   = 0,
    localparam int FCH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CNT_W-1:0]          max_cycles_i,
    input  logic [NUM_CH-1:0]         exit_valid_i,
    input  logic [NUM_CH*VALUE_W-1:0] exit_value_i,
    output logic                      start_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      pass_o,
    output logic                      timeout_o,
    output logic [NUM_CH-1:0]         exited_o,
    output logic [FCH_W-1:0]          fail_ch_o,
    output logic [VALUE_W-1:0]        fail_value_o,
    output logic [CNT_W-1:0]          cycle_cnt_o
);

    ew_state_e           r_state;
    ew_state_e           w_state_nxt;
    logic [CNT_W-1:0]    w_hold_cnt;
    logic [CNT_W-1:0]    w_run_cnt;
    logic [NUM_CH-1:0]   w_new;
    logic [NUM_CH-1:0]   w_bad;
    logic [NUM_CH-1:0]   w_exited_nxt;
    logic [EW_MAX_CH-1:0] w_bad16;
    ew_first_t           w_first;
    logic [VALUE_W-1:0]  w_first_val;
    logic                w_fail_now;
    logic                w_finish;
    logic                w_timeout;

    logic                r_start;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic                r_timeout;
    logic                r_fail_seen;
    logic [NUM_CH-1:0]   r_exited;
    logic [FCH_W-1:0]    r_fail_ch;
    logic [VALUE_W-1:0]  r_fail_value;

    ew_sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_clr (r_state != S_WAIT),
        .i_en  (r_state == S_WAIT),
        .o_cnt (w_hold_cnt)
    );

    ew_sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_clr ((r_state == S_WAIT) || (r_state == S_START)),
        .i_en  (r_state == S_RUN),
        .o_cnt (w_run_cnt)
    );

    // New exits this cycle, and which of them carry a nonzero value.
    always_comb begin
        w_new   = exit_valid_i & ~r_exited;
        w_bad   = '0;
        w_bad16 = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_bad[k] = w_new[k] &&
                (exit_value_i[k*VALUE_W +: VALUE_W] != '0);
        end
        w_bad16[NUM_CH-1:0] = w_bad;
    end

    assign w_first = first_set_idx(w_bad16);

    // Value of the winning failing channel.
    always_comb begin
        w_first_val = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (4'(k) == w_first.idx) begin
                w_first_val = exit_value_i[k*VALUE_W +: VALUE_W];
            end
        end
    end

    assign w_fail_now   = w_first.found && !r_fail_seen;
    assign w_exited_nxt = r_exited | exit_valid_i;
    assign w_finish     = (MODE_ALL != 0) ? (&w_exited_nxt)
                                          : (|exit_valid_i);
    assign w_timeout    = (max_cycles_i != '0) &&
                          (w_run_cnt >= max_cycles_i) && !w_finish;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: hold-off, one-cycle start, run until finish or timeout.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_WAIT: begin
                if (w_hold_cnt == CNT_W'(RESET_WAIT - 1)) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_finish || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_WAIT;
        endcase
    end

    // Registered status flags and RUN-phase exit/fail/timeout capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_fail_seen  <= 1'b0;
            r_exited     <= '0;
            r_fail_ch    <= '0;
            r_fail_value <= '0;
        end else begin
            r_start <= (w_state_nxt == S_START);
            r_busy  <= (w_state_nxt == S_RUN);
            r_done  <= (w_state_nxt == S_DONE);
            if (r_state == S_RUN) begin
                r_exited <= w_exited_nxt;
                if (w_fail_now) begin
                    r_fail_seen  <= 1'b1;
                    r_fail_ch    <= w_first.idx[FCH_W-1:0];
                    r_fail_value <= w_first_val;
                end
                if (w_timeout) begin
                    r_timeout <= 1'b1;
                end
                if (w_finish || w_timeout) begin
                    r_pass <= !w_timeout && !r_fail_seen &&
                              !w_first.found;
                end
            end
        end
    end

    assign start_o      = r_start;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign pass_o       = r_pass;
    assign timeout_o    = r_timeout;
    assign exited_o     = r_exited;
    assign fail_ch_o    = r_fail_ch;
    assign fail_value_o = r_fail_value;
    assign cycle_cnt_o  = w_run_cnt;

endmodule

// File: tb/tb_exit_watchdog.sv
// Directed bench for exit_watchdog: first-exit and all-exit
// instances on shared stimulus, plus a narrow single-channel one.
module tb_exit_watchdog;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] max_cycles = '0;
    logic [1:0]  valid = '0;
    logic [63:0] value = '0;

    logic        a_start, a_busy, a_done, a_pass, a_timeout;
    logic [1:0]  a_exited;
    logic        a_fail_ch;
    logic [31:0] a_fail_value, a_cycle;

    logic        b_start, b_busy, b_done, b_pass, b_timeout;
    logic [1:0]  b_exited;
    logic        b_fail_ch;
    logic [31:0] b_fail_value, b_cycle;

    logic [5:0]  c_max = '0;
    logic [0:0]  c_valid = '0;
    logic [7:0]  c_value = '0;
    logic        c_start, c_busy, c_done, c_pass, c_timeout;
    logic [0:0]  c_exited;
    logic [0:0]  c_fail_ch;
    logic [7:0]  c_fail_value;
    logic [5:0]  c_cycle;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exit_watchdog #(
        .NUM_CH(2), .VALUE_W(32), .CNT_W(32),
        .RESET_WAIT(50), .MODE_ALL(0)
    ) u_a (
        .clk_i(clk), .rst_i(rst), .max_cycles_i(max_cycles),
        .exit_valid_i(valid), .exit_value_i(value),
        .start_o(a_start), .busy_o(a_busy), .done_o(a_done),
        .pass_o(a_pass), .timeout_o(a_timeout),
        .exited_o(a_exited), .fail_ch_o(a_fail_ch),
        .fail_value_o(a_fail_value), .cycle_cnt_o(a_cycle)
    );

    exit_watchdog #(
        .NUM_CH(2), .VALUE_W(32), .CNT_W(32),
        .RESET_WAIT(50), .MODE_ALL(1)
    ) u_b (
        .clk_i(clk), .rst_i(rst), .max_cycles_i(max_cycles),
        .exit_valid_i(valid), .exit_value_i(value),
        .start_o(b_start), .busy_o(b_busy), .done_o(b_done),
        .pass_o(b_pass), .timeout_o(b_timeout),
        .exited_o(b_exited), .fail_ch_o(b_fail_ch),
        .fail_value_o(b_fail_value), .cycle_cnt_o(b_cycle)
    );

    exit_watchdog #(
        .NUM_CH(1), .VALUE_W(8), .CNT_W(6),
        .RESET_WAIT(3), .MODE_ALL(0)
    ) u_c (
        .clk_i(clk), .rst_i(rst), .max_cycles_i(c_max),
        .exit_valid_i(c_valid), .exit_value_i(c_value),
        .start_o(c_start), .busy_o(c_busy), .done_o(c_done),
        .pass_o(c_pass), .timeout_o(c_timeout),
        .exited_o(c_exited), .fail_ch_o(c_fail_ch),
        .fail_value_o(c_fail_value), .cycle_cnt_o(c_cycle)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: last reset edge just passed.
    task automatic do_reset();
        rst = 1'b1;
        valid = '0;
        value = '0;
        c_valid = '0;
        c_value = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Leaves the bench in RUN cycle 0 (cycle 51).
    task automatic reset_to_run();
        do_reset();
        repeat (51) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid = 2'b11;
        value = {32'd9, 32'd8};
        c_valid = 1'b1;
        c_value = 8'd4;
        repeat (3) tick();
        total++;
        if ({a_start, a_busy, a_done, a_pass, a_timeout,
             a_exited, a_fail_ch} !== 8'b0) begin
            bad++;
            $display("FAIL reset_a_flags got=%b want=0",
                {a_start, a_busy, a_done, a_pass, a_timeout,
                 a_exited, a_fail_ch});
        end
        total++;
        if ({a_fail_value, a_cycle} !== 64'd0) begin
            bad++;
            $display("FAIL reset_a_vals got=%h want=0",
                {a_fail_value, a_cycle});
        end
        total++;
        if ({b_start, b_busy, b_done, b_pass, b_timeout,
             b_exited, b_fail_ch, b_fail_value, b_cycle} !== 72'd0) begin
            bad++;
            $display("FAIL reset_b got=%h want=0",
                {b_start, b_busy, b_done, b_pass, b_timeout,
                 b_exited, b_fail_ch, b_fail_value, b_cycle});
        end
        total++;
        if ({c_start, c_busy, c_done, c_pass, c_timeout,
             c_exited, c_fail_ch, c_fail_value, c_cycle} !== 21'd0) begin
            bad++;
            $display("FAIL reset_c got=%h want=0",
                {c_start, c_busy, c_done, c_pass, c_timeout,
                 c_exited, c_fail_ch, c_fail_value, c_cycle});
        end
    endtask

    task automatic test_holdoff();
        logic [1:0] exp_a;
        logic [1:0] exp_c;
        do_reset();
        for (int cyc = 0; cyc <= 60; cyc++) begin
            exp_a = {cyc == 50, cyc >= 51};
            exp_c = {cyc == 3, cyc >= 4};
            total++;
            if ({a_start, a_busy} !== exp_a) begin
                bad++;
                $display("FAIL holdoff_a cyc=%0d got=%b want=%b",
                    cyc, {a_start, a_busy}, exp_a);
            end
            total++;
            if ({c_start, c_busy} !== exp_c) begin
                bad++;
                $display("FAIL holdoff_c cyc=%0d got=%b want=%b",
                    cyc, {c_start, c_busy}, exp_c);
            end
            tick();
        end
    endtask

    task automatic test_single_pass();
        max_cycles = '0;
        reset_to_run();
        repeat (10) tick();
        valid = 2'b10;
        value = '0;
        tick();
        valid = '0;
        total++;
        if ({a_done, a_pass, a_busy, a_timeout} !== 4'b1100) begin
            bad++;
            $display("FAIL pass_flags got=%b want=1100",
                {a_done, a_pass, a_busy, a_timeout});
        end
        total++;
        if (a_exited !== 2'b10) begin
            bad++;
            $display("FAIL pass_exited got=%b want=10", a_exited);
        end
        total++;
        if (a_cycle !== 32'd11) begin
            bad++;
            $display("FAIL pass_cycle got=%0d want=11", a_cycle);
        end
        total++;
        if ({b_done, b_busy, b_exited} !== 4'b0110) begin
            bad++;
            $display("FAIL pass_all_pending got=%b want=0110",
                {b_done, b_busy, b_exited});
        end
        valid = 2'b01;
        value = {32'd0, 32'd5};
        repeat (2) tick();
        valid = '0;
        total++;
        if ({a_done, a_pass, a_exited, a_cycle} !== {4'b1110, 32'd11}) begin
            bad++;
            $display("FAIL done_absorb got=%h want=%h",
                {a_done, a_pass, a_exited, a_cycle}, {4'b1110, 32'd11});
        end
    endtask

    task automatic test_simultaneous_fail();
        reset_to_run();
        repeat (3) tick();
        valid = 2'b11;
        value = {32'd3, 32'd7};
        tick();
        valid = '0;
        total++;
        if ({a_done, a_pass, a_fail_ch, a_exited} !== 5'b10011) begin
            bad++;
            $display("FAIL simul_flags got=%b want=10011",
                {a_done, a_pass, a_fail_ch, a_exited});
        end
        total++;
        if (a_fail_value !== 32'd7) begin
            bad++;
            $display("FAIL simul_value got=%0d want=7", a_fail_value);
        end
        total++;
        if ({b_done, b_pass, b_fail_ch, b_fail_value} !== {3'b100, 32'd7})
        begin
            bad++;
            $display("FAIL simul_all got=%h want=%h",
                {b_done, b_pass, b_fail_ch, b_fail_value}, {3'b100, 32'd7});
        end
        valid = 2'b10;
        value = {32'd9, 32'd0};
        tick();
        valid = '0;
        total++;
        if ({a_fail_ch, a_fail_value, a_pass} !== {1'b0, 32'd7, 1'b0})
        begin
            bad++;
            $display("FAIL simul_later got=%h want=%h",
                {a_fail_ch, a_fail_value, a_pass}, {1'b0, 32'd7, 1'b0});
        end
    endtask

    task automatic test_all_mode();
        max_cycles = '0;
        reset_to_run();
        repeat (5) tick();
        valid = 2'b01;
        value = '0;
        tick();
        valid = '0;
        total++;
        if ({b_done, b_busy, b_exited} !== 4'b0101) begin
            bad++;
            $display("FAIL all_first got=%b want=0101",
                {b_done, b_busy, b_exited});
        end
        repeat (14) tick();
        total++;
        if ({b_done, b_busy} !== 2'b01) begin
            bad++;
            $display("FAIL all_wait got=%b want=01", {b_done, b_busy});
        end
        valid = 2'b10;
        value = '0;
        tick();
        valid = '0;
        total++;
        if ({b_done, b_pass, b_busy, b_exited} !== 5'b11011) begin
            bad++;
            $display("FAIL all_pass got=%b want=11011",
                {b_done, b_pass, b_busy, b_exited});
        end
        total++;
        if (b_cycle !== 32'd21) begin
            bad++;
            $display("FAIL all_cycle got=%0d want=21", b_cycle);
        end

        reset_to_run();
        repeat (5) tick();
        valid = 2'b01;
        value = '0;
        tick();
        valid = '0;
        repeat (14) tick();
        valid = 2'b10;
        value = {32'd4, 32'd0};
        tick();
        valid = '0;
        total++;
        if ({b_done, b_pass, b_fail_ch, b_fail_value} !== {3'b101, 32'd4})
        begin
            bad++;
            $display("FAIL all_fail got=%h want=%h",
                {b_done, b_pass, b_fail_ch, b_fail_value}, {3'b101, 32'd4});
        end

        reset_to_run();
        repeat (2) tick();
        valid = 2'b01;
        value = {32'd0, 32'd5};
        tick();
        value = {32'd0, 32'd8};
        tick();
        valid = '0;
        total++;
        if ({b_done, b_busy, b_fail_ch, b_fail_value} !== {3'b010, 32'd5})
        begin
            bad++;
            $display("FAIL all_keep_first got=%h want=%h",
                {b_done, b_busy, b_fail_ch, b_fail_value}, {3'b010, 32'd5});
        end
        valid = 2'b10;
        value = {32'd6, 32'd0};
        tick();
        valid = '0;
        total++;
        if ({b_done, b_pass, b_fail_ch, b_fail_value} !== {3'b100, 32'd5})
        begin
            bad++;
            $display("FAIL all_no_overwrite got=%h want=%h",
                {b_done, b_pass, b_fail_ch, b_fail_value}, {3'b100, 32'd5});
        end
    endtask

    task automatic test_timeout();
        max_cycles = 32'd100;
        reset_to_run();
        repeat (100) tick();
        total++;
        if ({a_done, a_busy, a_timeout} !== 3'b010) begin
            bad++;
            $display("FAIL tmo_edge got=%b want=010",
                {a_done, a_busy, a_timeout});
        end
        tick();
        total++;
        if ({a_done, a_timeout, a_pass, a_busy} !== 4'b1100) begin
            bad++;
            $display("FAIL tmo_fire got=%b want=1100",
                {a_done, a_timeout, a_pass, a_busy});
        end
        total++;
        if (a_cycle !== 32'd101) begin
            bad++;
            $display("FAIL tmo_cycle got=%0d want=101", a_cycle);
        end

        reset_to_run();
        repeat (100) tick();
        valid = 2'b01;
        value = '0;
        tick();
        valid = '0;
        total++;
        if ({a_done, a_timeout, a_pass} !== 3'b101) begin
            bad++;
            $display("FAIL tmo_tie got=%b want=101",
                {a_done, a_timeout, a_pass});
        end
        total++;
        if ({b_done, b_timeout, b_pass, b_exited} !== 5'b11001) begin
            bad++;
            $display("FAIL tmo_tie_all got=%b want=11001",
                {b_done, b_timeout, b_pass, b_exited});
        end

        max_cycles = '0;
        reset_to_run();
        repeat (10000) tick();
        total++;
        if ({a_done, a_timeout, a_busy, a_cycle} !== {3'b001, 32'd10000})
        begin
            bad++;
            $display("FAIL no_tmo got=%h want=%h",
                {a_done, a_timeout, a_busy, a_cycle}, {3'b001, 32'd10000});
        end
    endtask

    task automatic test_saturate();
        c_max = '0;
        do_reset();
        repeat (4 + 70) tick();
        total++;
        if ({c_busy, c_done, c_cycle} !== {2'b10, 6'd63}) begin
            bad++;
            $display("FAIL sat_cycle got=%h want=%h",
                {c_busy, c_done, c_cycle}, {2'b10, 6'd63});
        end
        c_valid = 1'b1;
        c_value = 8'd5;
        tick();
        c_valid = '0;
        total++;
        if ({c_done, c_pass, c_exited, c_fail_ch, c_fail_value}
            !== {4'b1010, 8'd5}) begin
            bad++;
            $display("FAIL sat_fail got=%h want=%h",
                {c_done, c_pass, c_exited, c_fail_ch, c_fail_value},
                {4'b1010, 8'd5});
        end
    endtask

    task automatic test_reset_mid();
        max_cycles = '0;
        reset_to_run();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        total++;
        if ({a_start, a_busy, a_done, a_pass, a_timeout, a_exited,
             a_cycle} !== 39'd0) begin
            bad++;
            $display("FAIL rst_run got=%h want=0",
                {a_start, a_busy, a_done, a_pass, a_timeout, a_exited,
                 a_cycle});
        end
        rst = 1'b0;
        valid = 2'b11;
        value = {32'd2, 32'd1};
        for (int cyc = 0; cyc <= 50; cyc++) begin
            total++;
            if ({a_start, a_busy, a_exited} !== {cyc == 50, 3'b000}) begin
                bad++;
                $display("FAIL rst_wait cyc=%0d got=%b", cyc,
                    {a_start, a_busy, a_exited});
            end
            if (cyc == 50) valid = '0;
            tick();
        end
        total++;
        if ({a_busy, a_done, a_exited, a_fail_value} !== {4'b1000, 32'd0})
        begin
            bad++;
            $display("FAIL rst_wait_ignored got=%h want=%h",
                {a_busy, a_done, a_exited, a_fail_value}, {4'b1000, 32'd0});
        end

        valid = 2'b10;
        value = {32'd3, 32'd0};
        tick();
        valid = '0;
        total++;
        if ({a_done, a_pass, a_fail_ch, a_fail_value} !== {3'b101, 32'd3})
        begin
            bad++;
            $display("FAIL rst_pre_done got=%h want=%h",
                {a_done, a_pass, a_fail_ch, a_fail_value}, {3'b101, 32'd3});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({a_done, a_pass, a_timeout, a_exited, a_fail_ch,
             a_fail_value, a_cycle} !== 70'd0) begin
            bad++;
            $display("FAIL rst_done got=%h want=0",
                {a_done, a_pass, a_timeout, a_exited, a_fail_ch,
                 a_fail_value, a_cycle});
        end
        repeat (49) tick();
        total++;
        if ({a_start, a_busy} !== 2'b00) begin
            bad++;
            $display("FAIL rst_hold49 got=%b want=00", {a_start, a_busy});
        end
        tick();
        total++;
        if ({a_start, a_busy} !== 2'b10) begin
            bad++;
            $display("FAIL rst_hold50 got=%b want=10", {a_start, a_busy});
        end
        tick();
        total++;
        if ({a_start, a_busy, a_cycle} !== {2'b01, 32'd0}) begin
            bad++;
            $display("FAIL rst_hold51 got=%h want=%h",
                {a_start, a_busy, a_cycle}, {2'b01, 32'd0});
        end
    endtask

    initial begin
        test_reset();
        test_holdoff();
        test_single_pass();
        test_simultaneous_fail();
        test_all_mode();
        test_timeout();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
